// File: rtl/e_mdu_if.sv
// rtl/e_mdu_if.sv - E-stage MDU operand/control/result bundle
interface e_mdu_if;
  logic        Start;
  logic [2:0]  MDop;
  logic [1:0]  HILO_Rop;
  logic        Req;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HILO_out;

  modport master (
    output Start, MDop, HILO_Rop, Req, A, B,
    input  Busy, HILO_out
  );

  modport slave (
    input  Start, MDop, HILO_Rop, Req, A, B,
    output Busy, HILO_out
  );
endinterface

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - E-stage multiply/divide unit with HI/LO registers
// Define MDU_MADD_EN to enable madd on MDop 111.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic   clk,
  input  logic   reset,
  e_mdu_if.slave mdu
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi, lo, hi_tmp, lo_tmp;
  logic             div_zero;

  logic        busy_r, op_valid, acc, sdiv;
  logic [63:0] prod_s, prod_u;
  logic [31:0] dvd, dvs, dvs_nz, quot_u, rem_u, quot, rem;

  assign busy_r = (cnt != '0);

  always_comb begin
    op_valid = 1'b0;
    case (mdu.MDop)
      3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110: op_valid = 1'b1;
`ifdef MDU_MADD_EN
      3'b111: op_valid = 1'b1;
`endif
      default: op_valid = 1'b0;
    endcase
  end

  assign acc = mdu.Start & ~mdu.Req & ~busy_r & op_valid;

  assign prod_s = {{32{mdu.A[31]}}, mdu.A} * {{32{mdu.B[31]}}, mdu.B};
  assign prod_u = {32'd0, mdu.A} * {32'd0, mdu.B};

  // Signed divide runs on magnitudes so INT_MIN / -1 wraps to INT_MIN with no overflow trap.
  assign sdiv   = (mdu.MDop == 3'b011);
  assign dvd    = (sdiv & mdu.A[31]) ? (~mdu.A + 32'd1) : mdu.A;
  assign dvs    = (sdiv & mdu.B[31]) ? (~mdu.B + 32'd1) : mdu.B;
  assign dvs_nz = (dvs == 32'd0) ? 32'd1 : dvs;
  assign quot_u = dvd / dvs_nz;
  assign rem_u  = dvd % dvs_nz;
  assign quot   = (sdiv & (mdu.A[31] ^ mdu.B[31])) ? (~quot_u + 32'd1) : quot_u;
  assign rem    = (sdiv & mdu.A[31]) ? (~rem_u + 32'd1) : rem_u;

  assign mdu.Busy = busy_r | acc;

  always_comb begin
    case (mdu.HILO_Rop)
      2'b01:   mdu.HILO_out = hi;
      2'b10:   mdu.HILO_out = lo;
      default: mdu.HILO_out = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      hi_tmp   <= 32'd0;
      lo_tmp   <= 32'd0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc) begin
            case (mdu.MDop)
              3'b001: begin
                {hi_tmp, lo_tmp} <= prod_s;
                div_zero         <= 1'b0;
                cnt              <= CNT_W'(MULT_CYCLES);
                state            <= RUN;
              end
              3'b010: begin
                {hi_tmp, lo_tmp} <= prod_u;
                div_zero         <= 1'b0;
                cnt              <= CNT_W'(MULT_CYCLES);
                state            <= RUN;
              end
              3'b011, 3'b100: begin
                hi_tmp   <= rem;
                lo_tmp   <= quot;
                div_zero <= (mdu.B == 32'd0);
                cnt      <= CNT_W'(DIV_CYCLES);
                state    <= RUN;
              end
              3'b101: hi <= mdu.A;
              3'b110: lo <= mdu.A;
`ifdef MDU_MADD_EN
              3'b111: begin
                {hi_tmp, lo_tmp} <= {hi, lo} + prod_s;
                div_zero         <= 1'b0;
                cnt              <= CNT_W'(MULT_CYCLES);
                state            <= RUN;
              end
`endif
              default: ;
            endcase
          end
        end
        RUN: begin
          // Starts are never accepted here, so Req cannot disturb a running op.
          if (cnt == CNT_W'(1)) begin
            if (!div_zero) begin
              hi <= hi_tmp;
              lo <= lo_tmp;
            end
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
